// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, canonical NOP and ALU opcodes.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0 -- what the decoder sees while no real instruction is held
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Clears the byte-offset bits so every PC is a word address
    localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

    // Fetch control: issue a request, wait for its response, or drain a
    // response that a redirect made stale
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // ALU operation encoding used by the execute stage
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with next-PC selection (redirect beats advance).
module fetch_pc_gen
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc
);

    logic [31:0] pc_next;

    // Redirect target wins; otherwise step one word (wraps at 2^32) or hold
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_pc & WORD_MASK;
        end else if (advance) begin
            pc_next = pc + 32'd4;
        end
    end

    // PC register, word-aligned from reset onward
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC & WORD_MASK;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding memory request, one-entry output slot,
// redirect handling that discards in-flight responses.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    fetch_state_e state, state_next;
    logic [31:0]  pc;
    logic         slot_free;
    logic         capture;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk         (clk_i),
        .rst         (rst_i),
        .advance     (capture),
        .redirect    (redirect_i),
        .redirect_pc (redirect_pc_i),
        .pc          (pc)
    );

    // A new request may only go out if its response will have somewhere to land
    assign slot_free = !instr_valid_o || instr_ready_i;

    // pc only moves on capture or redirect, so the address holds while stalled
    assign imem_addr_o = pc;

    // Next-state and request logic; a redirect never lets a response in flight
    // reach the slot
    always_comb begin
        state_next = state;
        imem_req_o = 1'b0;
        capture    = 1'b0;
        case (state)
            REQ: begin
                imem_req_o = !rst_i && slot_free;
                if (imem_req_o && imem_ready_i) begin
                    state_next = redirect_i ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    capture    = !redirect_i;
                    state_next = REQ;
                end else if (redirect_i) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                // The stale response is the one still owed; once it arrives
                // nothing is outstanding, even if another redirect lands now
                if (imem_rvalid_i) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = REQ;
            end
        endcase
    end

    // FSM state register; reset abandons any outstanding request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    // Output slot: redirect flushes it, a response fills it, a handshake empties it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_valid_o <= 1'b0;
            instr_o       <= NOP_INSTR;
            instr_pc_o    <= 32'h0000_0000;
        end else if (redirect_i) begin
            instr_valid_o <= 1'b0;
        end else if (capture) begin
            instr_valid_o <= 1'b1;
            instr_o       <= imem_rdata_i;
            instr_pc_o    <= pc;
        end else if (instr_valid_o && instr_ready_i) begin
            instr_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table plus
// hand-written redirect, reset and PC-wrap sequences.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_ready;

    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] ipc;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_vld;
    logic [31:0] w_instr;
    logic [31:0] w_ipc;

    int checks = 0;
    int errors = 0;

    instruction_fetch dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ready_i  (mem_ready),
        .imem_rvalid_i (mem_rvalid),
        .imem_rdata_i  (mem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (vld),
        .instr_o       (instr),
        .instr_pc_o    (ipc),
        .instr_ready_i (dec_ready)
    );

    instruction_fetch #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (w_req),
        .imem_addr_o   (w_addr),
        .imem_ready_i  (mem_ready),
        .imem_rvalid_i (mem_rvalid),
        .imem_rdata_i  (mem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (w_vld),
        .instr_o       (w_instr),
        .instr_pc_o    (w_ipc),
        .instr_ready_i (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mrdy;
        logic        rv;
        logic [31:0] rdata;
        logic        rd;
        logic [31:0] rdpc;
        logic        dry;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle's inputs at the falling edge; outputs settle 1 time unit later
    task automatic drive(input logic r, input logic mr, input logic rv, input logic [31:0] rdat,
                         input logic rd, input logic [31:0] rdp, input logic dr);
        @(negedge clk);
        rst         = r;
        mem_ready   = mr;
        mem_rvalid  = rv;
        mem_rdata   = rdat;
        redirect    = rd;
        redirect_pc = rdp;
        dec_ready   = dr;
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;

        //                rst mrdy rv rdata          rd rdpc          dry | req addr          vld instr          ipc
        vq.push_back('{1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0,    1'b0, 1'b0,32'h0000_0000,1'b0,32'h0000_0013,32'h0});
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,         1'b0,32'h0,    1'b1, 1'b1,32'h0000_0000,1'b0,32'h0000_0013,32'h0});
        vq.push_back('{1'b0,1'b0,1'b1,32'hA000_0000, 1'b0,32'h0,    1'b1, 1'b0,32'h0000_0000,1'b0,32'h0000_0013,32'h0});
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,         1'b0,32'h0,    1'b1, 1'b1,32'h0000_0004,1'b1,32'hA000_0000,32'h0});
        vq.push_back('{1'b0,1'b0,1'b1,32'hA000_0004, 1'b0,32'h0,    1'b1, 1'b0,32'h0000_0004,1'b0,32'hA000_0000,32'h0});
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,         1'b0,32'h0,    1'b1, 1'b1,32'h0000_0008,1'b1,32'hA000_0004,32'h4});
        vq.push_back('{1'b0,1'b0,1'b1,32'hA000_0008, 1'b0,32'h0,    1'b1, 1'b0,32'h0000_0008,1'b0,32'hA000_0004,32'h4});
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,         1'b0,32'h0,    1'b1, 1'b1,32'h0000_000C,1'b1,32'hA000_0008,32'h8});
        vq.push_back('{1'b0,1'b0,1'b1,32'hA000_000C, 1'b0,32'h0,    1'b0, 1'b0,32'h0000_000C,1'b0,32'hA000_0008,32'h8});
        // decoder stalls five cycles with the slot full: no request, slot frozen
        for (int k = 0; k < 5; k++)
            vq.push_back('{1'b0,1'b1,1'b0,32'h0,     1'b0,32'h0,    1'b0, 1'b0,32'h0000_0010,1'b1,32'hA000_000C,32'hC});
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,         1'b0,32'h0,    1'b1, 1'b1,32'h0000_0010,1'b1,32'hA000_000C,32'hC});
        vq.push_back('{1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,    1'b1, 1'b0,32'h0000_0010,1'b0,32'hA000_000C,32'hC});
        vq.push_back('{1'b0,1'b0,1'b1,32'hA000_0010, 1'b0,32'h0,    1'b1, 1'b0,32'h0000_0010,1'b0,32'hA000_000C,32'hC});
        // memory not ready: address holds; stray rvalid in REQ is ignored
        vq.push_back('{1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,    1'b1, 1'b1,32'h0000_0014,1'b1,32'hA000_0010,32'h10});
        vq.push_back('{1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,    1'b1, 1'b1,32'h0000_0014,1'b0,32'hA000_0010,32'h10});
        vq.push_back('{1'b0,1'b1,1'b1,32'hDEAD_BEEF, 1'b0,32'h0,    1'b1, 1'b1,32'h0000_0014,1'b0,32'hA000_0010,32'h10});
        vq.push_back('{1'b0,1'b0,1'b1,32'hA000_0014, 1'b0,32'h0,    1'b0, 1'b0,32'h0000_0014,1'b0,32'hA000_0010,32'h10});
        // redirect in REQ without acceptance, same cycle as a handshake
        vq.push_back('{1'b0,1'b0,1'b0,32'h0,         1'b1,32'h302,  1'b1, 1'b1,32'h0000_0018,1'b1,32'hA000_0014,32'h14});
        vq.push_back('{1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,    1'b1, 1'b1,32'h0000_0300,1'b0,32'hA000_0014,32'h14});

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].mrdy, vq[i].rv, vq[i].rdata, vq[i].rd, vq[i].rdpc, vq[i].dry);
            chk($sformatf("v%0d.req", i),   {31'b0, req}, {31'b0, vq[i].e_req});
            chk($sformatf("v%0d.addr", i),  addr,         vq[i].e_addr);
            chk($sformatf("v%0d.vld", i),   {31'b0, vld}, {31'b0, vq[i].e_vld});
            chk($sformatf("v%0d.instr", i), instr,        vq[i].e_instr);
            chk($sformatf("v%0d.ipc", i),   ipc,          vq[i].e_ipc);
        end

        // Redirect to 0x100 while waiting on the response for 0x8
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 32'hA000_0000, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 32'hA000_0004, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 1);
        chk("wait_redir.req8", {31'b0, req}, 32'd1);
        chk("wait_redir.addr8", addr, 32'h8);
        drive(0, 0, 0, 0, 1, 32'h100, 1);
        chk("wait_redir.noreq", {31'b0, req}, 32'd0);
        drive(0, 0, 1, 32'hBAD0_0008, 0, 0, 1);
        chk("drop.noreq", {31'b0, req}, 32'd0);
        chk("drop.vld", {31'b0, vld}, 32'd0);
        drive(0, 1, 0, 0, 0, 0, 1);
        chk("after_drop.req", {31'b0, req}, 32'd1);
        chk("after_drop.addr", addr, 32'h100);
        drive(0, 0, 1, 32'hC000_0100, 0, 0, 1);
        chk("after_drop.vld0", {31'b0, vld}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("redir_fetch.vld", {31'b0, vld}, 32'd1);
        chk("redir_fetch.ipc", ipc, 32'h100);
        chk("redir_fetch.instr", instr, 32'hC000_0100);

        // Redirect to 0x203 in the same cycle the memory accepts 0x104
        drive(0, 1, 0, 0, 1, 32'h203, 1);
        chk("acc_redir.req", {31'b0, req}, 32'd1);
        chk("acc_redir.addr", addr, 32'h104);
        drive(0, 1, 0, 0, 0, 0, 1);
        chk("acc_redir.drop_noreq", {31'b0, req}, 32'd0);
        chk("acc_redir.vld", {31'b0, vld}, 32'd0);
        drive(0, 0, 1, 32'hBAD0_0104, 0, 0, 1);
        chk("acc_redir.drop_noreq2", {31'b0, req}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("acc_redir.next_req", {31'b0, req}, 32'd1);
        chk("acc_redir.next_addr", addr, 32'h200);

        // Redirect in WAIT together with the response: response discarded
        drive(0, 1, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 32'hBAD0_0200, 1, 32'h40, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("wait_rv_redir.req", {31'b0, req}, 32'd1);
        chk("wait_rv_redir.addr", addr, 32'h40);
        chk("wait_rv_redir.vld", {31'b0, vld}, 32'd0);

        // Reset during WAIT, then a late response
        drive(0, 1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("rst.noreq", {31'b0, req}, 32'd0);
        drive(0, 0, 1, 32'hBAD0_0040, 0, 0, 1);
        chk("rst.first_req", {31'b0, req}, 32'd1);
        chk("rst.first_addr", addr, 32'h0);
        chk("rst.late_vld", {31'b0, vld}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("rst.late_ignored", {31'b0, vld}, 32'd0);
        chk("rst.instr_nop", instr, 32'h0000_0013);
        drive(0, 1, 0, 0, 0, 0, 1);
        chk("rst.req_again", {31'b0, req}, 32'd1);
        drive(0, 0, 1, 32'hE000_0000, 0, 0, 1);
        chk("rst.vld_pending", {31'b0, vld}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst.refetch_vld", {31'b0, vld}, 32'd1);
        chk("rst.refetch_ipc", ipc, 32'h0);
        chk("rst.refetch_instr", instr, 32'hE000_0000);

        // PC wrap from RESET_PC = 0xFFFF_FFFC
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1);
        chk("wrap.req0", {31'b0, w_req}, 32'd1);
        chk("wrap.addr0", w_addr, 32'hFFFF_FFFC);
        drive(0, 0, 1, 32'h5555_AAAA, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 1);
        chk("wrap.req1", {31'b0, w_req}, 32'd1);
        chk("wrap.addr1", w_addr, 32'h0000_0000);
        chk("wrap.vld", {31'b0, w_vld}, 32'd1);
        chk("wrap.ipc", w_ipc, 32'hFFFF_FFFC);
        chk("wrap.instr", w_instr, 32'h5555_AAAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_i  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 imem_req_o  output  1  SHALL signal an instruction-memory read request.
REQ-005 imem_addr_o  output  32  SHALL carry the request word address, with bits [1:0] always 2'b00.
REQ-006 imem_ready_i  input  1  SHALL indicate that memory accepts the request this cycle.
REQ-007 imem_rvalid_i  input  1  SHALL indicate that imem_rdata_i holds the response this cycle.
REQ-008 imem_rdata_i  input  32  SHALL carry the fetched instruction word.
REQ-009 redirect_i  input  1  SHALL be the branch/jump taken redirect from execute.
REQ-010 redirect_pc_i  input  32  SHALL be the redirect target; bits [1:0] are ignored and treated as 00.
REQ-011 instr_valid_o  output  1  SHALL indicate that instr_o/instr_pc_o are valid for the decoder.
REQ-012 instr_o  output  32  SHALL be the instruction word presented to the decoder.
REQ-013 instr_pc_o  output  32  SHALL be the PC of instr_o.
REQ-014 instr_ready_i  input  1  SHALL indicate that the decoder consumes instr_o this cycle.

Function
REQ-015 Handshake: the decoder SHALL accept an instruction on any cycle where instr_valid_o && instr_ready_i; instr_o and instr_pc_o SHALL stay stable while valid && !ready.
REQ-016 At most one memory request SHALL be outstanding; output buffering SHALL be a single register slot.
REQ-017 The FSM SHALL have exactly three states: REQ, WAIT and DROP.
REQ-018 REQ: imem_req_o=1 when the slot is empty or being drained this cycle (!instr_valid_o || instr_ready_i), and imem_addr_o=pc.
REQ-019 REQ -> WAIT on imem_req_o && imem_ready_i.
REQ-020 In REQ, imem_addr_o SHALL hold while imem_req_o && !imem_ready_i, unless a redirect occurs.
REQ-021 WAIT: on imem_rvalid_i the block SHALL capture rdata into instr_o and the request address into instr_pc_o, set instr_valid_o=1 and pc=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), then go to REQ.
REQ-022 Response latency: the instruction SHALL be visible on instr_o one cycle after imem_rvalid_i.
REQ-023 Redirect SHALL take priority over all other events: pc <= {redirect_pc_i[31:2],2'b00} and instr_valid_o <= 0 on the next cycle, discarding any unconsumed instruction.
REQ-024 Redirect in REQ without acceptance SHALL withdraw the request and leave the state at REQ; the next request uses the new pc.
REQ-025 Redirect in REQ in the same cycle as imem_ready_i SHALL move the FSM to DROP.
REQ-026 Redirect in WAIT without imem_rvalid_i SHALL move the FSM to DROP.
REQ-027 Redirect in WAIT with imem_rvalid_i SHALL discard the response and move the FSM to REQ.
REQ-028 DROP: imem_req_o=0; on imem_rvalid_i the response SHALL be discarded and the FSM goes to REQ.
REQ-029 Redirect in DROP SHALL update pc and keep the FSM in DROP.
REQ-030 imem_rvalid_i in state REQ SHALL be ignored.
REQ-031 A redirect in the same cycle as a decoder handshake SHALL still complete that handshake; the consumed instruction is not replayed.

Reset
REQ-032 On rst_i the outputs and state SHALL take these values: pc=RESET_PC, state=REQ, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), instr_pc_o=0.
REQ-033 imem_req_o SHALL be 0 during any cycle in which rst_i is high.
REQ-034 Reset during WAIT or DROP SHALL abandon the outstanding request; a late response SHALL be ignored because the FSM is in REQ (REQ-030).
REQ-035 The first request SHALL issue on the first cycle after rst_i deasserts.

Structure
REQ-036 The FSM state enum and the NOP constant (32'h0000_0013) SHALL live in shared package cpu_pkg, alongside the existing ALU package usage.
REQ-037 Next-PC selection and the PC register SHALL be one sub-module, fetch_pc_gen (inputs: advance, redirect, redirect_pc; output: pc).

Verification
REQ-038 Reset, then memory with ready=1 and 1-cycle rvalid, decoder ready=1 -> instr_pc_o sequence 0,4,8,12 with matching rdata; first valid within 3 cycles of reset release.
REQ-039 Decoder ready=0 for 5 cycles with the slot full -> instr_o/instr_pc_o stable and imem_req_o=0 until ready rises; no instruction lost or duplicated.
REQ-040 In WAIT for pc 0x8, assert redirect to 0x100 before rvalid -> response for 0x8 dropped; next valid instr_pc_o=0x100.
REQ-041 Redirect to 0x203 in the same cycle as imem_ready_i -> DROP entered; next request address 0x200.
REQ-042 RESET_PC=32'hFFFF_FFFC -> second request address 0x0000_0000 (wrap).
REQ-043 Assert rst_i during WAIT, then deliver a late rvalid -> response ignored; instr_valid_o stays 0 until the new fetch from RESET_PC returns.
